// File: rtl/shift_reg_seq.sv
// Parallel-load shift/rotate register that performs a programmed number of
// single-position steps, one per clock, under a start/busy/done handshake.
module shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  input  logic [2:0]       mode,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam logic [2:0] M_SHL = 3'b000;
  localparam logic [2:0] M_SHR = 3'b001;
  localparam logic [2:0] M_ROL = 3'b010;
  localparam logic [2:0] M_ROR = 3'b011;
  localparam logic [2:0] M_ASR = 3'b100;

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       mode_q,  mode_d;
  logic             cin_q,   cin_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             cout_q,  cout_d;
  logic             done_q,  done_d;
  logic [WIDTH:0]   step_res;

  // One single-position step; returns {cout, data}. Reserved modes hold both.
  function automatic logic [WIDTH:0] step_f(input logic [2:0]       m,
                                            input logic             c,
                                            input logic [WIDTH-1:0] d,
                                            input logic             co);
    logic [WIDTH:0] r;
    case (m)
      M_SHL:   r = {d[WIDTH-1], d[WIDTH-2:0], c};
      M_SHR:   r = {d[0], c, d[WIDTH-1:1]};
      M_ROL:   r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      M_ROR:   r = {d[0], d[0], d[WIDTH-1:1]};
      M_ASR:   r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      default: r = {co, d};
    endcase
    return r;
  endfunction

  assign step_res = step_f(mode_q, cin_q, data_q, cout_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    data_d  = data_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          data_d = in;
        end else if (start) begin
          if (amount != '0) begin
            state_d = ST_SHIFT;
            cnt_d   = amount;
            mode_d  = mode;
            cin_d   = cin;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        // load/start are deliberately not looked at here: no queuing while busy.
        {cout_d, data_d} = step_res;
        cnt_d            = cnt_q - 1'b1;
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      cin_q   <= 1'b0;
      data_q  <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      data_q  <= data_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign out  = data_q;
  assign cout = cout_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq: a vector table of load/start operations
// followed by hand-written sequences for reset and handshake corner cases.
module tb_shift_reg_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] in;
  logic       start;
  logic [3:0] amount;
  logic [2:0] mode;
  logic       cin;
  logic [7:0] out;
  logic       cout;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .in(in), .start(start),
    .amount(amount), .mode(mode), .cin(cin), .out(out), .cout(cout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ld;
    logic [2:0] md;
    logic       ci;
    logic [3:0] n;
    logic [7:0] exp_out;
    logic       exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    load = 1'b1; in = v; start = 1'b0;
    @(negedge clk);
    load = 1'b0; in = 8'h00;
  endtask

  // Issues start, then scrambles mode/cin while busy, counts busy/done cycles.
  task automatic run_op(input string name, input logic [2:0] md, input logic ci,
                        input logic [3:0] n, input logic [7:0] exp_out, input logic exp_cout);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    start = 1'b1; mode = md; cin = ci; amount = n;
    @(negedge clk);
    start = 1'b0; mode = ~md; cin = ~ci; amount = 4'hF;
    for (int i = 0; i < int'(n) + 4; i++) begin
      if (i > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
    chk({name, " busy_cycles"}, busy_cnt, n);
    chk({name, " done_count"}, done_cnt, 1);
    chk({name, " done_at"}, done_at, n);
    chk({name, " out"}, out, exp_out);
    chk({name, " cout"}, cout, exp_cout);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{8'hA5, 3'b000, 1'b1, 4'd3,  8'h2F, 1'b1};
    vecs[1] = '{8'h81, 3'b011, 1'b0, 4'd1,  8'hC0, 1'b1};
    vecs[2] = '{8'h01, 3'b010, 1'b0, 4'd9,  8'h02, 1'b0};
    vecs[3] = '{8'h90, 3'b100, 1'b1, 4'd2,  8'hE4, 1'b0};
    vecs[4] = '{8'hE4, 3'b110, 1'b1, 4'd2,  8'hE4, 1'b0};
    vecs[5] = '{8'h5A, 3'b001, 1'b1, 4'd12, 8'hFF, 1'b1};
    vecs[6] = '{8'h3C, 3'b000, 1'b0, 4'd15, 8'h00, 1'b0};

    rst_n = 1'b0; load = 1'b0; in = 8'h00; start = 1'b0;
    amount = 4'd0; mode = 3'b000; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset between edges
    @(negedge clk);
    load = 1'b1; in = 8'hFF;
    @(posedge clk);
    #2;
    chk("pre_reset out", out, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("async_reset out", out, 8'h00);
    chk("async_reset cout", cout, 1'b0);
    chk("async_reset busy", busy, 1'b0);
    chk("async_reset done", done, 1'b0);
    #1;
    load = 1'b0;
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      do_load(vecs[v].ld);
      if (v != 4) chk($sformatf("vec%0d load", v), out, vecs[v].ld);
      run_op($sformatf("vec%0d", v), vecs[v].md, vecs[v].ci, vecs[v].n,
             vecs[v].exp_out, vecs[v].exp_cout);
    end

    // load and start asserted during busy are ignored
    do_load(8'h01);
    start = 1'b1; mode = 3'b000; cin = 1'b0; amount = 4'd5;
    @(negedge clk);
    load = 1'b1; in = 8'hFF; start = 1'b1; amount = 4'd2;
    repeat (3) @(negedge clk);
    chk("ignore busy_mid", busy, 1'b1);
    load = 1'b0; start = 1'b0;
    begin
      int t = 0;
      while (!done && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("ignore done_seen", done, 1'b1);
    end
    chk("ignore out", out, 8'h20);
    @(negedge clk);
    chk("ignore no_restart", busy, 1'b0);
    chk("ignore done_single", done, 1'b0);

    // Reset in the middle of an operation
    do_load(8'h01);
    start = 1'b1; mode = 3'b000; cin = 1'b0; amount = 4'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midop out_step2", out, 8'h04);
    rst_n = 1'b0;
    #1;
    chk("midop_reset out", out, 8'h00);
    chk("midop_reset busy", busy, 1'b0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midop_after busy", busy, 1'b0);

    // amount = 0
    do_load(8'h77);
    start = 1'b1; amount = 4'd0; mode = 3'b000; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero busy", busy, 1'b0);
    chk("zero done", done, 1'b1);
    chk("zero out", out, 8'h77);
    @(negedge clk);
    chk("zero done_drop", done, 1'b0);

    // load beats start in the same cycle
    load = 1'b1; in = 8'h3C; start = 1'b1; amount = 4'd3;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    chk("loadprio out", out, 8'h3C);
    chk("loadprio busy", busy, 1'b0);
    chk("loadprio done", done, 1'b0);

    // start accepted in the done cycle
    do_load(8'h01);
    start = 1'b1; mode = 3'b000; cin = 1'b1; amount = 4'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("b2b done1", done, 1'b1);
    chk("b2b out1", out, 8'h03);
    start = 1'b1; cin = 1'b0; amount = 4'd1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy2", busy, 1'b1);
    @(negedge clk);
    chk("b2b done2", done, 1'b1);
    chk("b2b out2", out, 8'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
